uart_tx_serializer: RTL and testbench

Serial UART transmitter that answers the FIR wrapper's transmit handshake. It accepts one byte per `txd_start` pulse and shifts it out on `txd` as one 8N1 frame, LSB first. It holds `txd_busy` high for the whole frame. It sits between the wrapper's output byte mux and the board TX pin, mirroring the receiver that produces `rx_done`/`rx_data`.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_serializer_if.sv | 18 +
 rtl/baud_tick_gen.sv | 37 +++
 rtl/uart_tx_serializer.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter and its matching receiver.
// Contents: frame state encoding, data-bit count, default baud divider,
// even-parity helper.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 434;   // 50 MHz / 115200
    localparam int UART_BAUD_CNT_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Even parity bit: makes the total number of ones (data + parity) even.
    function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: transmit handshake between the byte source (wrapper)
// and the serializer.
//   txd_start  request to send tx_data (master -> slave)
//   tx_data    byte to send            (master -> slave)
//   txd_busy   frame in progress       (slave -> master)
//   tx_done    one-cycle end-of-frame  (slave -> master)
interface uart_tx_serializer_if;
    import uart_pkg::*;

    logic                      txd_start;
    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      txd_busy;
    logic                      tx_done;

    modport master (output txd_start, output tx_data, input txd_busy, input tx_done);
    modport slave  (input txd_start, input tx_data, output txd_busy, output tx_done);

endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit-period counter counting 0..CLKS_PER_BIT-1 with a
// synchronous clear. tick is high during the terminal-count cycle, and the
// counter wraps to 0 on that edge.
// Ports:
//   clk    system clock
//   rst    synchronous reset, active-high
//   clear  hold the counter at 0
//   tick   terminal count reached (bit boundary on the next edge)
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int CNT_W        = UART_BAUD_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == TERMINAL);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: sends one byte per accepted txd_start as an 8N1 frame,
// LSB first, on the registered line txd. Define UART_TX_PARITY_EN for 8E1
// (an even parity bit after data bit 7).
// Ports:
//   clk    system clock
//   rst    synchronous reset, active-high
//   tx_if  slave side of the transmit handshake (txd_start, tx_data in;
//          txd_busy, tx_done out)
//   txd    serial line, idle high
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | line high, waiting for txd_start
// ST_START  | start bit (0)
// ST_DATA   | data bits, shift[0] on the line, LSB first
// ST_PARITY | even parity bit (only with UART_TX_PARITY_EN)
// ST_STOP   | stop bit (1); busy drops and tx_done pulses at its end
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_serializer_if.slave  tx_if,
    output logic                 txd
);

`ifdef UART_TX_PARITY_EN
    localparam int IDX_W = 4;
`else
    localparam int IDX_W = 3;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    uart_state_t               state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      txd_q, txd_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      tick;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    // Counter is held at 0 while idle, so acceptance always starts a full bit.
    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (UART_BAUD_CNT_W)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == ST_IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Outputs are computed one edge early so txd/busy/done come straight
    // from flops: the line value for the next bit is loaded at each boundary.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (tx_if.txd_start) begin
                    shift_d = tx_if.tx_data;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    txd_d   = 1'b0;
                    state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = uart_even_parity(tx_if.tx_data);
`endif
                end
            end

            ST_START: begin
                if (tick) begin
                    idx_d   = '0;
                    txd_d   = shift_q[0];
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = ST_PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        txd_d = shift_q[1];
                    end
                end
            end

            ST_PARITY: begin
                if (tick) begin
                    txd_d   = 1'b1;
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                if (tick) begin
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign txd            = txd_q;
    assign tx_if.txd_busy = busy_q;
    assign tx_if.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: randomized bench for uart_tx_serializer with
// CLKS_PER_BIT=4. A frame-level reference model predicts txd/txd_busy/tx_done
// every cycle from the acceptance time and the captured byte; a line decoder
// recovers bytes from txd and matches them against the accepted-byte queue.
// Honours UART_TX_PARITY_EN.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd;

    uart_tx_serializer_if tx_if ();

    uart_tx_serializer #(.CLKS_PER_BIT(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (tx_if),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Line level cyc cycles after acceptance: bit slot = cyc / N.
    function automatic logic line_level(input logic [7:0] d, input int cyc);
        int b;
        b = cyc / N;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Reference model, advanced on every rising edge from the inputs alone.
    bit         m_valid = 0;
    bit         m_busy  = 0;
    bit         m_done  = 0;
    int         m_cnt   = 0;
    logic [7:0] m_byte  = 8'h00;
    logic [7:0] sent_q[$];
    bit         rx_flush = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            m_busy  = 0;
            m_done  = 0;
            m_cnt   = 0;
            sent_q.delete();
            rx_flush = 1;
        end else if (m_busy) begin
            m_cnt++;
            m_done = 0;
            if (m_cnt == FRAME_CYC) begin
                m_busy = 0;
                m_done = 1;
            end
        end else begin
            m_done = 0;
            if (tx_if.txd_start === 1'b1) begin
                m_busy = 1;
                m_cnt  = 0;
                m_byte = tx_if.tx_data;
                sent_q.push_back(tx_if.tx_data);
            end
        end
    end

    int         dut_done_cnt = 0;
    int         rx_frames    = 0;
    bit         rx_act       = 0;
    int         rx_cnt       = 0;
    logic [7:0] rx_byte      = 8'h00;

    always @(negedge clk) begin
        if (m_valid) begin
            check("txd", txd, m_busy ? line_level(m_byte, m_cnt) : 1'b1);
            check("txd_busy", tx_if.txd_busy, m_busy);
            check("tx_done", tx_if.tx_done, m_done);
            if (tx_if.tx_done === 1'b1) dut_done_cnt++;

            if (rx_flush) begin
                rx_act   = 0;
                rx_flush = 0;
            end
            if (!rx_act) begin
                if (txd === 1'b0) begin
                    rx_act = 1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % N == N / 2) begin
                    int slot;
                    slot = rx_cnt / N;
                    if (slot >= 1 && slot <= 8) begin
                        rx_byte[slot-1] = txd;
`ifdef UART_TX_PARITY_EN
                    end else if (slot == 9) begin
                        check("rx_parity", txd, ^rx_byte);
`endif
                    end else if (slot == FRAME_BITS - 1) begin
                        check("rx_stop", txd, 1'b1);
                        if (sent_q.size() == 0) begin
                            check("rx_unexpected_frame", 32'(rx_byte), 32'h1ff);
                        end else begin
                            check("rx_byte", rx_byte, sent_q.pop_front());
                        end
                        rx_frames++;
                        rx_act = 0;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (tx_if.txd_busy !== 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("idle_timeout", n, 0);
    endtask

    // noise: 0 none, 1 txd_start with 8'hFF mid-frame, 2 random requests
    task automatic send_frame(input logic [7:0] d, input int noise);
        int len;
        int done0;
        int frames0;
        len     = 0;
        done0   = dut_done_cnt;
        frames0 = rx_frames;
        wait_idle();
        tx_if.txd_start = 1'b1;
        tx_if.tx_data   = d;
        @(negedge clk);
        tx_if.txd_start = 1'b0;
        tx_if.tx_data   = 8'($urandom);
        while (tx_if.txd_busy === 1'b1 && len < FRAME_CYC + 8) begin
            len++;
            if (noise != 0 && $urandom_range(0, 3) == 0) begin
                tx_if.txd_start = 1'b1;
                tx_if.tx_data   = (noise == 1) ? 8'hFF : 8'($urandom);
            end else begin
                tx_if.txd_start = 1'b0;
            end
            @(negedge clk);
        end
        tx_if.txd_start = 1'b0;
        check("busy_len", len, FRAME_CYC);
        @(negedge clk);
        check("done_pulses", dut_done_cnt - done0, 1);
        check("frames_decoded", rx_frames - frames0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int done0;
        int frames0;
        int low;
        int len;

        tx_if.txd_start = 1'b0;
        tx_if.tx_data   = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_busy", tx_if.txd_busy, 1'b0);
        check("rst_done", tx_if.tx_done, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic frame, then a frame with ignored 8'hFF requests
        send_frame(8'hA5, 0);
        send_frame(8'h5A, 1);
        repeat (3) @(negedge clk);

        // back-to-back: start held high across two frames
        done0   = dut_done_cnt;
        frames0 = rx_frames;
        tx_if.txd_start = 1'b1;
        tx_if.tx_data   = 8'h00;
        @(negedge clk);
        tx_if.tx_data = 8'h81;
        len = 0;
        while (tx_if.txd_busy === 1'b1 && len < FRAME_CYC + 8) begin
            len++;
            @(negedge clk);
        end
        check("b2b_len1", len, FRAME_CYC);
        low = 0;
        while (tx_if.txd_busy !== 1'b1 && low < 10) begin
            low++;
            @(negedge clk);
        end
        tx_if.txd_start = 1'b0;
        check("b2b_gap", low, 1);
        wait_idle();
        @(negedge clk);
        check("b2b_done", dut_done_cnt - done0, 2);
        check("b2b_frames", rx_frames - frames0, 2);

        // reset during data bit 3
        done0 = dut_done_cnt;
        tx_if.txd_start = 1'b1;
        tx_if.tx_data   = 8'($urandom);
        @(negedge clk);
        tx_if.txd_start = 1'b0;
        check("accept_busy", tx_if.txd_busy, 1'b1);
        repeat (4 * N + 1) @(negedge clk);
        rst = 1'b1;
        tx_if.txd_start = 1'b1;    // dropped: reset wins
        @(negedge clk);
        rst = 1'b0;
        tx_if.txd_start = 1'b0;
        check("midrst_txd", txd, 1'b1);
        check("midrst_busy", tx_if.txd_busy, 1'b0);
        repeat (3) @(negedge clk);
        check("midrst_no_done", dut_done_cnt - done0, 0);
        check("midrst_idle", tx_if.txd_busy, 1'b0);
        send_frame(8'h3C, 0);

        // wrapper handshake: six random bytes in order
        frames0 = rx_frames;
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            tx_if.txd_start = 1'b1;
            tx_if.tx_data   = 8'($urandom);
            @(negedge clk);
            check("wrap_busy_after_start", tx_if.txd_busy, 1'b1);
            tx_if.txd_start = 1'b0;
        end
        wait_idle();
        repeat (2) @(negedge clk);
        check("wrap_frames", rx_frames - frames0, 6);

        // random frames with random spurious requests
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 2);

        // parity corner bytes (plain 8N1 frames in the default build)
        send_frame(8'h07, 0);
        send_frame(8'h03, 0);

        repeat (4) @(negedge clk);
        check("queue_drained", sent_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
